// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions for the 16-bit pipeline.
// Word and address widths, NOP encoding and fetch-buffer entry layout.
package instruction_fetch_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam word_t NOP_WORD = 16'h0800;

    typedef struct packed {
        word_t instr;
        addr_t pc_plus1;
    } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO holding fetched words with their pc+1.
// Flush empties the buffer in one cycle.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  fb_entry_t wdata,
    output fb_entry_t rdata,
    output logic [1:0] count,
    output logic      full,
    output logic      empty
);

    fb_entry_t mem [2];
    logic      wptr;
    logic      rptr;
    logic      do_push;
    logic      do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (do_pop)
                rptr <= ~rptr;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, request credits, response discard and IF/ID register.
// Credits are reserved at request time so a response always has a slot.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter addr_t RESET_PC  = 16'h0000,
    parameter word_t NOP_INSTR = NOP_WORD
) (
    input  logic  clk,
    input  logic  rst,
    output logic  imem_req,
    output addr_t imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  word_t imem_rdata,
    input  logic  stall,
    input  logic  redirect,
    input  addr_t redirect_pc,
    output logic  id_valid,
    output word_t id_instruction,
    output addr_t id_pc_plus1
);

    addr_t      pc;
    addr_t      resp_pc;
    logic [1:0] outstanding;
    logic [1:0] discard;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    fb_entry_t  fifo_head;
    logic [2:0] credit_used;
    logic [2:0] pending;
    logic       grant;
    logic       accept;
    logic       drop_resp;
    logic       bypass;
    logic       fifo_push;
    logic       fifo_pop;

    assign credit_used = {1'b0, outstanding} + {1'b0, discard}
                       + {1'b0, fifo_count};
    assign imem_req  = rst && !redirect && (credit_used < 3'd2);
    assign imem_addr = pc;

    assign grant     = imem_req && imem_gnt;
    assign accept    = imem_rvalid && (discard == 2'd0) && !redirect;
    assign drop_resp = imem_rvalid && (discard != 2'd0);
    assign bypass    = !stall && fifo_empty && accept;
    assign fifo_pop  = !redirect && !stall && !fifo_empty;
    assign fifo_push = accept && !bypass && (!fifo_full || fifo_pop);

    // Everything still owed by memory at a redirect becomes a discard.
    assign pending = {1'b0, discard} + {1'b0, outstanding}
                   - {2'b00, imem_rvalid};

    fetch_buffer u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect),
        .wdata ('{instr: imem_rdata, pc_plus1: resp_pc + 16'd1}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc             <= RESET_PC;
            resp_pc        <= RESET_PC;
            outstanding    <= 2'd0;
            discard        <= 2'd0;
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
            id_pc_plus1    <= RESET_PC;
        end else if (redirect) begin
            pc             <= redirect_pc;
            resp_pc        <= redirect_pc;
            discard        <= pending[1:0];
            outstanding    <= 2'd0;
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
        end else begin
            if (grant)
                pc <= pc + 16'd1;
            if (accept)
                resp_pc <= resp_pc + 16'd1;
            if (drop_resp)
                discard <= discard - 2'd1;
            unique case ({grant, accept})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
            if (!stall) begin
                unique case (1'b1)
                    !fifo_empty: begin
                        id_valid       <= 1'b1;
                        id_instruction <= fifo_head.instr;
                        id_pc_plus1    <= fifo_head.pc_plus1;
                    end
                    accept: begin
                        id_valid       <= 1'b1;
                        id_instruction <= imem_rdata;
                        id_pc_plus1    <= resp_pc + 16'd1;
                    end
                    default: begin
                        id_valid       <= 1'b0;
                        id_instruction <= NOP_INSTR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an in-order memory model.
// Memory responds the cycle after grant unless responses are held back.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic [15:0] id_instruction;
    logic [15:0] id_pc_plus1;

    logic        hold;
    logic [15:0] mem [65536];
    logic [15:0] q [$];
    logic [15:0] qa;
    int          total;
    int          bad;

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc_plus1    (id_pc_plus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pending responses are abandoned on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req && imem_gnt)
                q.push_back(imem_addr);
            if (!hold && q.size() > 0) begin
                qa = q.pop_front();
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem[qa];
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_id(input string tag, input logic [15:0] ins,
                          input logic [15:0] pc1);
        chk({tag, "_v"}, {15'd0, id_valid}, 16'h1);
        chk({tag, "_i"}, id_instruction, ins);
        chk({tag, "_p"}, id_pc_plus1, pc1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 65536; i++)
            mem[i] = 16'hA000 | 16'(i & 'hFFF);
        mem[0] = 16'h6801;
        mem[1] = 16'h6902;
        mem[2] = 16'h0800;
        rst = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        hold = 1'b0;
        imem_gnt = 1'b1;

        repeat (2) step();
        chk("rst_req", {15'd0, imem_req}, 16'h0);
        chk("rst_valid", {15'd0, id_valid}, 16'h0);
        chk("rst_instr", id_instruction, 16'h0800);
        chk("rst_pc1", id_pc_plus1, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);

        rst = 1'b1;
        #1;
        chk("c0_req", {15'd0, imem_req}, 16'h1);
        chk("c0_addr", imem_addr, 16'h0000);
        step();
        chk("c1_valid", {15'd0, id_valid}, 16'h0);
        step(); chk_id("c2", 16'h6801, 16'h0001);
        step(); chk_id("c3", 16'h6902, 16'h0002);
        step(); chk_id("c4", 16'h0800, 16'h0003);
        step(); chk_id("c5", 16'hA003, 16'h0004);

        stall = 1'b1;
        step();
        chk("st6_req", {15'd0, imem_req}, 16'h0);
        chk_id("st6", 16'hA003, 16'h0004);
        step();
        chk("st7_req", {15'd0, imem_req}, 16'h0);
        step();
        step();
        chk_id("st9", 16'hA003, 16'h0004);
        step();
        chk_id("st10", 16'hA003, 16'h0004);
        stall = 1'b0;
        step(); chk_id("c11", 16'hA004, 16'h0005);
        step(); chk_id("c12", 16'hA005, 16'h0006);
        step(); chk_id("c13", 16'hA006, 16'h0007);
        step(); chk_id("c14", 16'hA007, 16'h0008);

        hold = 1'b1;
        step(); chk_id("c15", 16'hA008, 16'h0009);
        step();
        chk("c16_req", {15'd0, imem_req}, 16'h0);
        chk("c16_valid", {15'd0, id_valid}, 16'h0);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        hold = 1'b0;
        #1;
        chk("c17_req", {15'd0, imem_req}, 16'h0);
        chk("c17_valid", {15'd0, id_valid}, 16'h0);
        step();
        chk("c18_req", {15'd0, imem_req}, 16'h0);
        chk("c18_valid", {15'd0, id_valid}, 16'h0);
        step();
        chk("c19_req", {15'd0, imem_req}, 16'h1);
        chk("c19_addr", imem_addr, 16'h0040);
        chk("c19_valid", {15'd0, id_valid}, 16'h0);
        step();
        chk("c20_valid", {15'd0, id_valid}, 16'h0);
        step(); chk_id("c21", 16'hA040, 16'h0041);
        step(); chk_id("c22", 16'hA041, 16'h0042);

        redirect = 1'b1;
        redirect_pc = 16'h0080;
        step();
        redirect = 1'b0;
        #1;
        chk("c23_req", {15'd0, imem_req}, 16'h1);
        chk("c23_addr", imem_addr, 16'h0080);
        chk("c23_valid", {15'd0, id_valid}, 16'h0);
        step();
        chk("c24_valid", {15'd0, id_valid}, 16'h0);
        step(); chk_id("c25", 16'hA080, 16'h0081);

        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        stall = 1'b0;
        redirect = 1'b0;
        #1;
        chk("c26_valid", {15'd0, id_valid}, 16'h0);
        chk("c26_instr", id_instruction, 16'h0800);
        chk("c26_addr", imem_addr, 16'hFFFE);
        chk("c26_req", {15'd0, imem_req}, 16'h1);
        step();
        chk("c27_addr", imem_addr, 16'hFFFF);
        step();
        chk_id("c28", 16'hAFFE, 16'hFFFF);
        chk("c28_addr", imem_addr, 16'h0000);
        step(); chk_id("c29", 16'hAFFF, 16'h0000);
        step(); chk_id("c30", 16'h6801, 16'h0001);

        stall = 1'b1;
        step();
        step();
        chk("c32_req", {15'd0, imem_req}, 16'h0);
        chk_id("c32", 16'h6801, 16'h0001);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {15'd0, id_valid}, 16'h0);
        chk("arst_instr", id_instruction, 16'h0800);
        chk("arst_pc1", id_pc_plus1, 16'h0000);
        chk("arst_req", {15'd0, imem_req}, 16'h0);
        chk("arst_addr", imem_addr, 16'h0000);
        step();
        step();
        stall = 1'b0;
        rst = 1'b1;
        #1;
        chk("r0_req", {15'd0, imem_req}, 16'h1);
        chk("r0_addr", imem_addr, 16'h0000);
        step();
        chk("r1_valid", {15'd0, id_valid}, 16'h0);
        step(); chk_id("r2", 16'h6801, 16'h0001);
        step(); chk_id("r3", 16'h6902, 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
